// File: rtl/tohost_exit_monitor.sv
// Watches host-write (tohost) words: forwards console bytes, counts unknown words and
// turns an exit word into a pass/fail verdict after a drain delay. Optional console path: TOHOST_CONSOLE_EN.
module tohost_exit_monitor #(
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tohost_valid,
  output logic        tohost_ready,
  input  logic [63:0] tohost_bits,
  output logic        console_valid,
  input  logic        console_ready,
  output logic [7:0]  console_data,
  output logic        io_success,
  output logic        io_failure,
  output logic [46:0] io_exit_code,
  output logic [7:0]  ignored_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid and its data stay stable until that edge, and ready never depends on valid.

`ifdef TOHOST_CONSOLE_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_CONSOLE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3
  } state_t;
`endif

  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [7:0]  drain_cnt;
  logic        accept;
  logic        is_exit;
  logic        is_console;
  logic        is_other;
  logic [46:0] word_code;

  assign tohost_ready = (state == S_IDLE);
  assign accept       = tohost_valid && tohost_ready;
  assign word_code    = tohost_bits[47:1];

  // Exit decode wins over everything; device 0 without bit 0 falls through to "other".
  assign is_exit    = (tohost_bits[63:56] == 8'd0) && tohost_bits[0];
  assign is_console = !is_exit && (tohost_bits[63:56] == 8'd1) && (tohost_bits[55:48] == 8'd1);
  assign is_other   = !is_exit && !is_console;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_exit) begin
            if (DRAIN_CYCLES == 0)
              state_next = (word_code == 47'd0) ? S_PASS : S_FAIL;
            else
              state_next = S_DRAIN;
          end
`ifdef TOHOST_CONSOLE_EN
          else if (is_console) begin
            state_next = S_CONSOLE;
          end
`endif
        end
      end
      S_DRAIN: begin
        if (drain_cnt == 8'd0)
          state_next = (io_exit_code == 47'd0) ? S_PASS : S_FAIL;
      end
`ifdef TOHOST_CONSOLE_EN
      S_CONSOLE: begin
        if (console_ready)
          state_next = S_IDLE;
      end
`endif
      S_PASS:  state_next = S_PASS;
      S_FAIL:  state_next = S_FAIL;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      io_success    <= 1'b0;
      io_failure    <= 1'b0;
      io_exit_code  <= '0;
      drain_cnt     <= '0;
      ignored_count <= '0;
    end else begin
      state      <= state_next;
      io_success <= (state_next == S_PASS);
      io_failure <= (state_next == S_FAIL);
      if (accept) begin
        if (is_exit) begin
          io_exit_code <= word_code;
          drain_cnt    <= DRAIN_INIT;
        end else if (is_other && (ignored_count != 8'hFF)) begin
          ignored_count <= ignored_count + 8'd1;
        end
      end else if ((state == S_DRAIN) && (drain_cnt != 8'd0)) begin
        drain_cnt <= drain_cnt - 8'd1;
      end
    end
  end

`ifdef TOHOST_CONSOLE_EN
  assign console_valid = (state == S_CONSOLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      console_data <= '0;
    else if (accept && is_console)
      console_data <= tohost_bits[7:0];
  end
`else
  // Console words are swallowed without effect when the console path is left out.
  logic unused_console;
  assign unused_console = console_ready;
  assign console_valid  = 1'b0;
  assign console_data   = 8'd0;
`endif

endmodule

// File: tb/tb_tohost_exit_monitor.sv
// Directed bench for tohost_exit_monitor: verdict timing, exit priority, ignore saturation,
// mid-drain reset and the console path in whichever build TOHOST_CONSOLE_EN selects.
module tb_tohost_exit_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tohost_valid = 1'b0;
  logic        tohost_ready;
  logic [63:0] tohost_bits = '0;
  logic        console_valid;
  logic        console_ready = 1'b0;
  logic [7:0]  console_data;
  logic        io_success;
  logic        io_failure;
  logic [46:0] io_exit_code;
  logic [7:0]  ignored_count;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       seen_console_valid = 1'b0;

  tohost_exit_monitor #(.DRAIN_CYCLES(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .tohost_valid  (tohost_valid),
    .tohost_ready  (tohost_ready),
    .tohost_bits   (tohost_bits),
    .console_valid (console_valid),
    .console_ready (console_ready),
    .console_data  (console_data),
    .io_success    (io_success),
    .io_failure    (io_failure),
    .io_exit_code  (io_exit_code),
    .ignored_count (ignored_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (console_valid) seen_console_valid <= 1'b1;
    if (console_valid && console_ready) got_q.push_back(console_data);
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // driver: present a word and hold it until the accept edge
  task automatic send_word(input logic [63:0] w);
    int n = 0;
    @(negedge clock);
    tohost_valid = 1'b1;
    tohost_bits  = w;
    while (!tohost_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!tohost_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clock);
      #1;
    end
    tohost_valid = 1'b0;
  endtask

  // After an accept edge: verdict must be absent after edge +16 and present after +17.
  task automatic expect_verdict(input string tag, input logic pass, input logic [46:0] code);
    repeat (16) @(posedge clock);
    @(negedge clock);
    check({tag, "_early_succ"}, 64'(io_success), 64'd0);
    check({tag, "_early_fail"}, 64'(io_failure), 64'd0);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_success"}, 64'(io_success), 64'(pass));
    check({tag, "_failure"}, 64'(io_failure), 64'(!pass));
    check({tag, "_code"}, 64'(io_exit_code), 64'(code));
    check({tag, "_ready"}, 64'(tohost_ready), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_ready", 64'(tohost_ready), 64'd1);
    check("rst_success", 64'(io_success), 64'd0);
    check("rst_failure", 64'(io_failure), 64'd0);
    check("rst_code", 64'(io_exit_code), 64'd0);
    check("rst_ignored", 64'(ignored_count), 64'd0);
    check("rst_cvalid", 64'(console_valid), 64'd0);
    check("rst_cdata", 64'(console_data), 64'd0);

    // pass verdict, then terminal: further words are not consumed
    send_word(64'h1);
    expect_verdict("pass", 1'b1, 47'd0);
    @(negedge clock);
    tohost_valid = 1'b1;
    tohost_bits  = 64'h0200_0000_0000_0000;
    repeat (3) @(negedge clock);
    tohost_valid = 1'b0;
    check("term_success", 64'(io_success), 64'd1);
    check("term_ready", 64'(tohost_ready), 64'd0);
    check("term_ignored", 64'(ignored_count), 64'd0);

    // fail verdict
    apply_reset();
    send_word(64'h7);
    expect_verdict("fail", 1'b0, 47'd3);

    // device 0 with bit 0 clear is just an ignored word
    apply_reset();
    @(negedge clock);
    check("rst2_code", 64'(io_exit_code), 64'd0);
    check("rst2_failure", 64'(io_failure), 64'd0);
    send_word(64'h2);
    @(negedge clock);
    check("prio_ignored", 64'(ignored_count), 64'd1);
    check("prio_ready", 64'(tohost_ready), 64'd1);
    check("prio_code", 64'(io_exit_code), 64'd0);

    // 300 unknown-device words saturate the counter
    for (int i = 0; i < 300; i++)
      send_word({8'h02, 8'($urandom_range(0, 255)), 48'(i)});
    @(negedge clock);
    check("sat_ignored", 64'(ignored_count), 64'd255);
    check("sat_ready", 64'(tohost_ready), 64'd1);
    check("sat_success", 64'(io_success), 64'd0);
    check("sat_failure", 64'(io_failure), 64'd0);

    // reset in the middle of the drain abandons the verdict
    send_word(64'h1);
    repeat (8) @(posedge clock);
    @(negedge clock);
    check("mid_ready_busy", 64'(tohost_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("mid_ready", 64'(tohost_ready), 64'd1);
    check("mid_ignored", 64'(ignored_count), 64'd0);
    check("mid_success", 64'(io_success), 64'd0);
    check("mid_failure", 64'(io_failure), 64'd0);
    repeat (20) @(negedge clock);
    check("mid_no_verdict", 64'(io_success | io_failure), 64'd0);
    reset = 1'b1;
    send_word(64'h1);
    expect_verdict("after_rst", 1'b1, 47'd0);

    apply_reset();
`ifdef TOHOST_CONSOLE_EN
    begin
      int valid_cycles = 0;
      exp_q.push_back(8'h41);
      console_ready = 1'b0;
      send_word(64'h0101_0000_0000_0041);
      for (int i = 1; i <= 20; i++) begin
        @(negedge clock);
        if (console_valid) begin
          valid_cycles++;
          check("con_data", 64'(console_data), 64'h41);
        end
        console_ready = (i >= 6);
      end
      console_ready = 1'b0;
      check("con_valid_cycles", 64'(valid_cycles), 64'd6);
      check("con_transfers", 64'(got_q.size()), 64'd1);
      while (got_q.size() > 0 && exp_q.size() > 0)
        check("con_byte", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
      check("con_ready_after", 64'(tohost_ready), 64'd1);
      check("con_ignored", 64'(ignored_count), 64'd0);
    end
`else
    console_ready = 1'b1;
    send_word(64'h0101_0000_0000_0041);
    repeat (3) @(negedge clock);
    console_ready = 1'b0;
    check("nocon_valid", 64'(seen_console_valid), 64'd0);
    check("nocon_data", 64'(console_data), 64'd0);
    check("nocon_ignored", 64'(ignored_count), 64'd0);
    check("nocon_ready", 64'(tohost_ready), 64'd1);
`endif
    send_word(64'h1);
    expect_verdict("con_exit", 1'b1, 47'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
